// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared definitions for the decode control bundle and the hazard/forwarding block.
package ctrl_pipe_hazard_pkg;

    localparam int RA_W    = 5;
    localparam int ALUOP_W = 2;

    localparam logic [ALUOP_W-1:0] ALUOP_LDST  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 2'b11;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Decoder control bundle; field order is the contract with the decoder.
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regwrite;
        logic               memwrite;
        logic               memread;
        logic               mem2reg;
        logic               branch;
    } ctrl_t;

    // Control fields carried into ID/EX (branch is resolved in ID and dropped).
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regwrite;
        logic               memwrite;
        logic               memread;
        logic               mem2reg;
    } ex_ctrl_t;

    function automatic ex_ctrl_t to_ex_ctrl(input ctrl_t c);
        ex_ctrl_t e;
        e.aluop    = c.aluop;
        e.alusrc   = c.alusrc;
        e.regwrite = c.regwrite;
        e.memwrite = c.memwrite;
        e.memread  = c.memread;
        e.mem2reg  = c.mem2reg;
        return e;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-to-pipeline control bundle and the pipeline control outputs.
interface ctrl_pipe_hazard_if;
    import ctrl_pipe_hazard_pkg::*;

    logic [ALUOP_W-1:0] ALUOp_i;
    logic               ALUSrc_i;
    logic               RegWrite_i;
    logic               MemWrite_i;
    logic               MemRead_i;
    logic               Mem2Reg_i;
    logic               Branch_i;
    logic [RA_W-1:0]    RS1addr_i;
    logic [RA_W-1:0]    RS2addr_i;
    logic [RA_W-1:0]    RDaddr_i;
    logic               Equal_i;

    logic               Stall_o;
    logic               Flush_o;
    logic [ALUOP_W-1:0] EX_ALUOp_o;
    logic               EX_ALUSrc_o;
    logic [1:0]         ForwardA_o;
    logic [1:0]         ForwardB_o;
    logic               MEM_MemWrite_o;
    logic               MEM_MemRead_o;
    logic [RA_W-1:0]    MEM_RDaddr_o;
    logic               WB_RegWrite_o;
    logic               WB_Mem2Reg_o;
    logic [RA_W-1:0]    WB_RDaddr_o;

    modport master (
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
               Branch_i, RS1addr_i, RS2addr_i, RDaddr_i, Equal_i,
        input  Stall_o, Flush_o, EX_ALUOp_o, EX_ALUSrc_o, ForwardA_o, ForwardB_o,
               MEM_MemWrite_o, MEM_MemRead_o, MEM_RDaddr_o,
               WB_RegWrite_o, WB_Mem2Reg_o, WB_RDaddr_o
    );

    modport slave (
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i,
               Branch_i, RS1addr_i, RS2addr_i, RDaddr_i, Equal_i,
        output Stall_o, Flush_o, EX_ALUOp_o, EX_ALUSrc_o, ForwardA_o, ForwardB_o,
               MEM_MemWrite_o, MEM_MemRead_o, MEM_RDaddr_o,
               WB_RegWrite_o, WB_Mem2Reg_o, WB_RDaddr_o
    );
endinterface

// File: rtl/ctrl_pipe_hazard_fwd_sel.sv
// Forwarding select for one EX operand; the younger EX/MEM result wins over MEM/WB.
module ctrl_pipe_hazard_fwd_sel
    import ctrl_pipe_hazard_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic [1:0]      sel
);

    // Priority select; x0 is never a forwarding source
    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
            sel = FWD_EXMEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
            sel = FWD_MEMWB;
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB), load-use stall, branch flush and EX forwarding.
module ctrl_pipe_hazard
    import ctrl_pipe_hazard_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    ctrl_pipe_hazard_if.slave bus
);

    ctrl_t           id_ctrl;

    ex_ctrl_t        ex_ctrl_reg;
    logic [RA_W-1:0] ex_rs1_reg;
    logic [RA_W-1:0] ex_rs2_reg;
    logic [RA_W-1:0] ex_rd_reg;

    logic            mem_regwrite_reg;
    logic            mem_memwrite_reg;
    logic            mem_memread_reg;
    logic            mem_mem2reg_reg;
    logic [RA_W-1:0] mem_rd_reg;

    logic            wb_regwrite_reg;
    logic            wb_mem2reg_reg;
    logic [RA_W-1:0] wb_rd_reg;

    logic            load_use;
    logic            stall;

    assign id_ctrl = '{aluop:    bus.ALUOp_i,
                       alusrc:   bus.ALUSrc_i,
                       regwrite: bus.RegWrite_i,
                       memwrite: bus.MemWrite_i,
                       memread:  bus.MemRead_i,
                       mem2reg:  bus.Mem2Reg_i,
                       branch:   bus.Branch_i};

    // Load in EX whose destination is read by the instruction in ID; reset masks both hazard outputs
    assign load_use = ex_ctrl_reg.memread && (ex_rd_reg != '0) &&
                      ((ex_rd_reg == bus.RS1addr_i) || (ex_rd_reg == bus.RS2addr_i));
    assign stall       = !rst_i && load_use;
    assign bus.Stall_o = stall;
    assign bus.Flush_o = !rst_i && id_ctrl.branch && bus.Equal_i && !load_use;

    // ID/EX: capture the decoded bundle, or a bubble while the ID instruction is held
    always_ff @(posedge clk_i) begin
        if (rst_i || stall) begin
            ex_ctrl_reg <= '0;
            ex_rs1_reg  <= '0;
            ex_rs2_reg  <= '0;
            ex_rd_reg   <= '0;
        end else begin
            ex_ctrl_reg <= to_ex_ctrl(id_ctrl);
            ex_rs1_reg  <= bus.RS1addr_i;
            ex_rs2_reg  <= bus.RS2addr_i;
            ex_rd_reg   <= bus.RDaddr_i;
        end
    end

    // EX/MEM and MEM/WB always advance; only reset clears them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_regwrite_reg <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_memread_reg  <= 1'b0;
            mem_mem2reg_reg  <= 1'b0;
            mem_rd_reg       <= '0;
            wb_regwrite_reg  <= 1'b0;
            wb_mem2reg_reg   <= 1'b0;
            wb_rd_reg        <= '0;
        end else begin
            mem_regwrite_reg <= ex_ctrl_reg.regwrite;
            mem_memwrite_reg <= ex_ctrl_reg.memwrite;
            mem_memread_reg  <= ex_ctrl_reg.memread;
            mem_mem2reg_reg  <= ex_ctrl_reg.mem2reg;
            mem_rd_reg       <= ex_rd_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_mem2reg_reg   <= mem_mem2reg_reg;
            wb_rd_reg        <= mem_rd_reg;
        end
    end

    // One forwarding selector per EX source operand (0 = rs1/A, 1 = rs2/B)
    logic [RA_W-1:0] ex_rs [2];
    logic [1:0]      fwd   [2];

    assign ex_rs[0] = ex_rs1_reg;
    assign ex_rs[1] = ex_rs2_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            ctrl_pipe_hazard_fwd_sel u_fwd_sel (
                .rs           (ex_rs[gi]),
                .mem_rd       (mem_rd_reg),
                .mem_regwrite (mem_regwrite_reg),
                .wb_rd        (wb_rd_reg),
                .wb_regwrite  (wb_regwrite_reg),
                .sel          (fwd[gi])
            );
        end
    endgenerate

    assign bus.ForwardA_o     = fwd[0];
    assign bus.ForwardB_o     = fwd[1];
    assign bus.EX_ALUOp_o     = ex_ctrl_reg.aluop;
    assign bus.EX_ALUSrc_o    = ex_ctrl_reg.alusrc;
    assign bus.MEM_MemWrite_o = mem_memwrite_reg;
    assign bus.MEM_MemRead_o  = mem_memread_reg;
    assign bus.MEM_RDaddr_o   = mem_rd_reg;
    assign bus.WB_RegWrite_o  = wb_regwrite_reg;
    assign bus.WB_Mem2Reg_o   = wb_mem2reg_reg;
    assign bus.WB_RDaddr_o    = wb_rd_reg;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: reset, forwarding, load-use stall, x0, branch flush, reset mid-stall.
module tb_ctrl_pipe_hazard;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_hazard_if bus ();

    ctrl_pipe_hazard dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int aluop, input int alusrc, input int rw, input int mw,
                         input int mr, input int m2r, input int br, input int eq,
                         input int rs1, input int rs2, input int rd);
        bus.ALUOp_i    = 2'(aluop);
        bus.ALUSrc_i   = 1'(alusrc);
        bus.RegWrite_i = 1'(rw);
        bus.MemWrite_i = 1'(mw);
        bus.MemRead_i  = 1'(mr);
        bus.Mem2Reg_i  = 1'(m2r);
        bus.Branch_i   = 1'(br);
        bus.Equal_i    = 1'(eq);
        bus.RS1addr_i  = 5'(rs1);
        bus.RS2addr_i  = 5'(rs2);
        bus.RDaddr_i   = 5'(rd);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_exop"},  8'(bus.EX_ALUOp_o),     8'h0);
        chk({tag, "_exsrc"}, 8'(bus.EX_ALUSrc_o),    8'h0);
        chk({tag, "_fwa"},   8'(bus.ForwardA_o),     8'h0);
        chk({tag, "_fwb"},   8'(bus.ForwardB_o),     8'h0);
        chk({tag, "_memw"},  8'(bus.MEM_MemWrite_o), 8'h0);
        chk({tag, "_memr"},  8'(bus.MEM_MemRead_o),  8'h0);
        chk({tag, "_memrd"}, 8'(bus.MEM_RDaddr_o),   8'h0);
        chk({tag, "_wbrw"},  8'(bus.WB_RegWrite_o),  8'h0);
        chk({tag, "_wbm2r"}, 8'(bus.WB_Mem2Reg_o),   8'h0);
        chk({tag, "_wbrd"},  8'(bus.WB_RDaddr_o),    8'h0);
    endtask

    initial begin
        // 1. reset with random inputs (branch taken forced to prove reset masks flush)
        rst = 1'b1;
        drive(int'($urandom_range(3)), int'($urandom_range(1)), 1, 1, 1, 1, 1, 1,
              int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)));
        tick();
        drive(int'($urandom_range(3)), 1, 1, int'($urandom_range(1)), 1, 1, 1, 1,
              int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)));
        tick();
        chk_zero("rst");
        chk("rst_stall", 8'(bus.Stall_o), 8'h0);
        chk("rst_flush", 8'(bus.Flush_o), 8'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_zero("first");

        // 2. EX/MEM forward, MEM/WB forward, priority
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3);   // add x3
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 3, 4, 6);   // sub reads x3
        tick();
        chk("fw_exmem_a",  8'(bus.ForwardA_o),   8'h2);
        chk("fw_exmem_b",  8'(bus.ForwardB_o),   8'h0);
        chk("fw_exop",     8'(bus.EX_ALUOp_o),   8'h2);
        chk("fw_memrd",    8'(bus.MEM_RDaddr_o), 8'h3);
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 3);   // add x3
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 7);   // unrelated, writes x7
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 3, 7, 8);   // reads x3 and x7
        tick();
        chk("fw_memwb_a",  8'(bus.ForwardA_o),    8'h1);
        chk("fw_exmem_b2", 8'(bus.ForwardB_o),    8'h2);
        chk("fw_wbrd",     8'(bus.WB_RDaddr_o),   8'h3);
        chk("fw_wbrw",     8'(bus.WB_RegWrite_o), 8'h1);
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 9);
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 9);
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 9, 9, 10);
        tick();
        chk("fw_prio_a",   8'(bus.ForwardA_o), 8'h2);
        chk("fw_prio_b",   8'(bus.ForwardB_o), 8'h2);

        // 3. load-use: lw x5 then add reading x5
        drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 5);
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 6, 5, 10);
        chk("lu_stall",    8'(bus.Stall_o), 8'h1);
        chk("lu_flush",    8'(bus.Flush_o), 8'h0);
        tick();
        chk("lu_bub_op",   8'(bus.EX_ALUOp_o),    8'h0);
        chk("lu_bub_src",  8'(bus.EX_ALUSrc_o),   8'h0);
        chk("lu_memr",     8'(bus.MEM_MemRead_o), 8'h1);
        chk("lu_memrd",    8'(bus.MEM_RDaddr_o),  8'h5);
        chk("lu_stall1",   8'(bus.Stall_o),       8'h0);
        tick();
        chk("lu_fwb",      8'(bus.ForwardB_o),    8'h1);
        chk("lu_fwa",      8'(bus.ForwardA_o),    8'h0);
        chk("lu_wbm2r",    8'(bus.WB_Mem2Reg_o),  8'h1);
        chk("lu_wbrd",     8'(bus.WB_RDaddr_o),   8'h5);
        chk("lu_exop",     8'(bus.EX_ALUOp_o),    8'h2);
        chk("lu_memr0",    8'(bus.MEM_MemRead_o), 8'h0);

        // 4. x0 is never a hazard or forwarding source
        drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0);   // lw x0
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // reads x0
        chk("x0_stall",    8'(bus.Stall_o), 8'h0);
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0);   // add x0
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 0, 3, 11);  // reads x0
        tick();
        chk("x0_fwa",      8'(bus.ForwardA_o), 8'h0);
        chk("x0_fwb",      8'(bus.ForwardB_o), 8'h0);

        // 5. branch flush, not-taken, and branch stalled on a load
        drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0);
        chk("br_taken",    8'(bus.Flush_o), 8'h1);
        bus.Equal_i = 1'b0;
        #1;
        chk("br_ntaken",   8'(bus.Flush_o), 8'h0);
        tick();
        chk("br_exop",     8'(bus.EX_ALUOp_o), 8'h1);
        drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 7);   // lw x7
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 7, 2, 0);   // beq reading x7
        chk("brst_stall",  8'(bus.Stall_o), 8'h1);
        chk("brst_flush",  8'(bus.Flush_o), 8'h0);
        tick();
        chk("brrt_stall",  8'(bus.Stall_o), 8'h0);
        chk("brrt_flush",  8'(bus.Flush_o), 8'h1);
        tick();
        chk("brrt_exop",   8'(bus.EX_ALUOp_o), 8'h1);

        // 6. reset while a load is in MEM and a dependent is stalled in ID
        drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 5);   // lw x5
        tick();
        drive(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 6);   // lw x6
        tick();
        drive(2, 0, 1, 0, 0, 0, 0, 0, 6, 5, 12);  // depends on both
        chk("r6_stall",    8'(bus.Stall_o),       8'h1);
        chk("r6_memr",     8'(bus.MEM_MemRead_o), 8'h1);
        chk("r6_memrd",    8'(bus.MEM_RDaddr_o),  8'h5);
        rst = 1'b1;
        #1;
        chk("r6_stall_rst", 8'(bus.Stall_o), 8'h0);
        tick();
        chk_zero("r6");
        rst = 1'b0;
        #1;
        chk("r6_stall_after", 8'(bus.Stall_o), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
